// File: rtl/gpio_input_filter.sv
// Per-pin synchronizer plus stability filter for GPIO pad inputs, with
// one-cycle rise/fall pulses on accepted level changes.

module gpio_input_filter_lane #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic bypass,
  output logic filt,
  output logic filt_d
);
  localparam int            CW   = $clog2(FILTER_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CW-1:0]          cnt;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      filt   <= 1'b0;
      filt_d <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      filt_d <= filt;
      if (bypass) begin
        filt <= sync;
        cnt  <= '0;
      end else if (sync == filt) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        // Stable for the full window: accept and restart for the next change.
        filt <= sync;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module gpio_input_filter #(
  parameter int WIDTH         = 15,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 16
) (
  input  logic             io_clock,
  input  logic             io_reset,
  input  logic [WIDTH-1:0] io_pins_raw,
  input  logic [WIDTH-1:0] io_bypass,
  output logic [WIDTH-1:0] io_pins_read,
  output logic [WIDTH-1:0] io_rise,
  output logic [WIDTH-1:0] io_fall,
  output logic             io_changed
);
  logic [WIDTH-1:0] filt, filt_d;

  gpio_input_filter_lane #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_lane [WIDTH-1:0] (
    .clk   (io_clock),
    .rst   (io_reset),
    .raw   (io_pins_raw),
    .bypass(io_bypass),
    .filt  (filt),
    .filt_d(filt_d)
  );

  assign io_pins_read = filt;
  assign io_rise      = filt & ~filt_d;
  assign io_fall      = ~filt & filt_d;
  assign io_changed   = |(io_rise | io_fall);
endmodule

// File: doc/gpio_input_filter.md
GPIO_INPUT_FILTER -- requirements
Module: gpio_input_filter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 15, giving the number of GPIO pins filtered.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth per pin; legal range 2..4.
REQ-003 The block SHALL have parameter FILTER_CYCLES, default 16, giving the consecutive stable cycles required to accept a new level; legal range 1..65535.
REQ-004 The block SHALL have input io_clock, 1 bit: the single clock for all logic.
REQ-005 The block SHALL have input io_reset, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have input io_pins_raw, WIDTH bits: asynchronous pad levels taken from the IOBUF O outputs.
REQ-007 The block SHALL have input io_bypass, WIDTH bits: per-pin filter bypass, 1 = synchronize only.
REQ-008 The block SHALL have output io_pins_read, WIDTH bits: the filtered level, which drives the SoC io_per_gpio*_pins_read.
REQ-009 The block SHALL have output io_rise, WIDTH bits: per-pin one-cycle pulse on an accepted 0->1 transition.
REQ-010 The block SHALL have output io_fall, WIDTH bits: per-pin one-cycle pulse on an accepted 1->0 transition.
REQ-011 The block SHALL have output io_changed, 1 bit: OR of all io_rise and io_fall bits.

Function
REQ-012 Each pin SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is "sync[i]".
REQ-013 Each pin SHALL hold a filtered register "filt[i]" and a stability counter of width clog2(FILTER_CYCLES)+1.
REQ-014 Where sync[i] == filt[i], the counter SHALL clear to 0 on the next edge.
REQ-015 Where sync[i] != filt[i] and counter < FILTER_CYCLES-1, the counter SHALL increment by 1.
REQ-016 Where sync[i] != filt[i] and counter == FILTER_CYCLES-1, filt[i] SHALL load sync[i] and the counter SHALL clear on the same edge.
REQ-017 The counter SHALL never wrap; it saturates at FILTER_CYCLES-1 by construction of REQ-016.
REQ-018 A new level SHALL be accepted only after FILTER_CYCLES consecutive cycles of sync[i] differing from filt[i]; any shorter excursion SHALL be discarded and its counter cleared.
REQ-019 Latency from a raw pin change to io_pins_read SHALL be exactly SYNC_STAGES+FILTER_CYCLES clock edges.
REQ-020 FILTER_CYCLES == 1 SHALL give synchronize-only behaviour, with latency SYNC_STAGES+1.
REQ-021 With io_bypass[i]=1, filt[i] SHALL load sync[i] every cycle and the counter SHALL be held at 0; latency is SYNC_STAGES+1.
REQ-022 A change of io_bypass[i] SHALL take effect on the next edge; the counter SHALL clear on that edge.
REQ-023 io_pins_read SHALL equal filt directly, with no extra register.
REQ-024 A registered copy filt_d SHALL exist, with io_rise = filt & ~filt_d and io_fall = ~filt & filt_d.
REQ-025 Each pulse SHALL therefore be high exactly one cycle, coincident with the first cycle io_pins_read shows the new level.
REQ-026 Pins SHALL be fully independent; simultaneous transitions on several pins SHALL produce simultaneous pulses.
REQ-027 io_changed SHALL be combinational from io_rise and io_fall.

Reset
REQ-028 While io_reset=1 at an edge, all synchronizer flops, filt, filt_d and counters SHALL load 0.
REQ-029 During reset, io_pins_read, io_rise, io_fall and io_changed SHALL be 0.
REQ-030 Reset asserted mid-count SHALL discard the partial count, with no pulse produced.
REQ-031 Pins held high through reset SHALL produce a rise pulse SYNC_STAGES+FILTER_CYCLES edges after reset release.

Verification (WIDTH=4, SYNC_STAGES=2, FILTER_CYCLES=4)
REQ-032 Raw=4'b1111 held through reset, then reset released -> io_pins_read=0000 for 5 edges, =1111 at the 6th; io_rise=1111 for one cycle; io_changed=1 for that cycle only.
REQ-033 Raw[0] high for 3 cycles then low -> io_pins_read[0] stays 0; io_rise[0] never asserts.
REQ-034 Raw[1] 0->1 held, later 1->0 held -> io_pins_read[1] rises 6 edges after the rise, with a single io_rise[1] pulse; it falls 6 edges after the fall, with a single io_fall[1] pulse.
REQ-035 io_bypass[2]=1, raw[2] toggled every 2 cycles -> io_pins_read[2] follows with 3-edge latency; io_rise[2]/io_fall[2] alternate every 2 cycles.
REQ-036 Raw[3] high, io_reset pulsed for 1 cycle when counter=2, raw kept high -> no pulse during reset; io_pins_read[3] rises 6 edges after reset release.
REQ-037 Raw=4'b0101 and 4'b1010 alternating every 3 cycles for 40 cycles -> io_pins_read stays 0000; io_changed stays 0.
